gsu_cache_controller: RTL and testbench
=======================================

GSU_CACHE_CONTROLLER -- requirements
Module: gsu_cache_controller

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low; no other clock or reset inputs.
REQ-002 Ports, in order (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  instruction fetch request; held with fetch_addr stable until fetch_ready
- fetch_addr  in  16  program counter of requested byte
- fetch_ready  out  1  one-cycle pulse: fetch_data valid
- fetch_data  out  8  fetched instruction byte, registered
- cbr_load  in  1  CACHE instruction: load base, invalidate all lines
- cbr_value  in  12  new base bits [15:4]
- flush  in  1  invalidate all lines, base unchanged
- cbr  out  16  current cache base, {base,4'h0}
- mem_req  out  1  external byte-read request
- mem_addr  out  16  external read address
- mem_ack  in  1  external read complete; mem_data valid same cycle
- mem_data  in  8  external read data
- ram_address  out  9  to 512x8 cache RAM (RAM registers address, read data valid next cycle)
- ram_inst  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_data  in  8  RAM read data

Function
REQ-003 Cache = 32 lines x 16 bytes; one valid bit per line; offset = (fetch_addr - cbr) mod 2^16; in range iff offset < 512; line = offset[8:4], byte = offset[3:0].
REQ-004 FSM states: IDLE, LOOKUP, READ, FILL, BYPASS, RESP.
REQ-005 IDLE: cbr_load has priority; if cbr_load, load base and clear all valid bits; a concurrent fetch_req is accepted the next cycle.
REQ-006 IDLE, fetch_req, in range, line valid -> LOOKUP; drive ram_address = offset[8:0], ram_we = 0.
REQ-007 LOOKUP -> READ (RAM data available); READ registers fetch_data <= ram_data, fetch_ready <= 1, -> RESP; hit latency: fetch_ready high 3 cycles after the request-accept edge.
REQ-008 IDLE, fetch_req, in range, line invalid -> FILL; byte counter = 0; mem_req = 1; mem_addr = cbr + {line,4'h0} + counter.
REQ-009 FILL: on each mem_ack: ram_we = 1, ram_address = {line,counter}, ram_inst = mem_data, counter++, mem_addr advances; mem_req stays high between bytes.
REQ-010 FILL: on 16th ack: mem_req low next cycle; set valid[line] unless an invalidate occurred during this fill; -> LOOKUP (re-read requested byte via RAM).
REQ-011 IDLE, fetch_req, out of range -> BYPASS: mem_req = 1, mem_addr = fetch_addr; on mem_ack: fetch_data <= mem_data, fetch_ready <= 1, -> RESP; no RAM write, no valid change.
REQ-012 RESP: fetch_ready low; -> IDLE; a new fetch_req is accepted in IDLE the following cycle.
REQ-013 cbr_load outside IDLE SHALL be ignored.
REQ-014 flush SHALL clear all valid bits in any state; during FILL the fill completes (all 16 writes) but that line stays invalid.
REQ-015 ram_we SHALL be high only in FILL cycles with mem_ack = 1; fetch_ready is never high for two consecutive cycles.
REQ-016 Offset arithmetic is modulo 2^16: cbr = 0xFF00, fetch_addr = 0x0050 -> offset 0x0150, in range.

Reset
REQ-017 rst_n low -> immediately: state IDLE, all valid bits 0, cbr 0x0000, counter 0, fetch_ready 0, fetch_data 0x00, mem_req 0, mem_addr 0x0000, ram_we 0, ram_address 0, ram_inst 0x00.
REQ-018 Reset mid-FILL or mid-BYPASS abandons the transaction; no valid bit is set.

Verification
REQ-019 Cold miss: cbr_load 0x010 (cbr 0x0100), fetch 0x0123 -> 16 mem reads 0x0120..0x012F with 16 ram_we writes to 0x020..0x02F; fetch_data = byte at 0x0123; valid[2] = 1.
REQ-020 Hit: repeat fetch 0x0125 -> no mem_req; fetch_ready 3 cycles after accept; fetch_data = RAM[0x025].
REQ-021 Bypass: cbr 0x0100, fetch 0x0400 -> single mem_req at 0x0400, no ram_we, fetch_ready after mem_ack.
REQ-022 Flush during fill: flush at 5th ack -> 16 writes complete; next fetch to same line refills it.
REQ-023 Wrap and priority: cbr 0xFF00, fetch 0x0050 -> fill line 0x15 from 0x0050..0x005F; cbr_load with fetch_req in IDLE -> valid cleared first, fetch served next cycle.

Source files
------------

// File: rtl/gsu_cache_controller.sv
// Instruction cache controller: 32 lines x 16 bytes windowed at cbr, fills lines from external memory.
// Latency: hit -> fetch_ready 3 cycles after accept; miss -> 16 memory reads then a hit lookup; bypass -> one read.
// Backpressure: fetch_req is held until the fetch_ready pulse; mem_req is held until each mem_ack.
module gsu_cache_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ready,
    output logic [7:0]  fetch_data,
    input  logic        cbr_load,
    input  logic [11:0] cbr_value,
    input  logic        flush,
    output logic [15:0] cbr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [8:0]  ram_address,
    output logic [7:0]  ram_inst,
    output logic        ram_we,
    input  logic [7:0]  ram_data
);

    typedef enum logic [2:0] {IDLE, LOOKUP, READ, FILL, BYPASS, RESP} state_t;

    state_t      state;
    logic [11:0] base;
    logic [31:0] valid;
    logic [3:0]  cnt;
    logic [4:0]  fill_line;
    logic        fill_inval;
    logic [8:0]  rd_addr;

    logic [15:0] offset;
    logic        in_range;
    logic [4:0]  req_line;

    assign cbr      = {base, 4'h0};
    assign offset   = fetch_addr - cbr;
    assign in_range = (offset[15:9] == 7'd0);
    assign req_line = offset[8:4];

    // RAM writes happen in the same cycle the memory byte arrives, so the write port is combinational.
    assign ram_we      = (state == FILL) && mem_ack;
    assign ram_inst    = ram_we ? mem_data : 8'h00;
    assign ram_address = (state == FILL) ? {fill_line, cnt} : rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= 12'h000;
            valid       <= 32'h0;
            cnt         <= 4'h0;
            fill_line   <= 5'h0;
            fill_inval  <= 1'b0;
            rd_addr     <= 9'h000;
            fetch_ready <= 1'b0;
            fetch_data  <= 8'h00;
            mem_req     <= 1'b0;
            mem_addr    <= 16'h0000;
        end else begin
            fetch_ready <= 1'b0;
            if (flush) begin
                valid <= 32'h0;
                if (state == FILL)
                    fill_inval <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cbr_load) begin
                        base  <= cbr_value;
                        valid <= 32'h0;
                    end else if (fetch_req) begin
                        if (in_range) begin
                            rd_addr <= offset[8:0];
                            if (valid[req_line]) begin
                                state <= LOOKUP;
                            end else begin
                                state      <= FILL;
                                fill_line  <= req_line;
                                cnt        <= 4'h0;
                                fill_inval <= 1'b0;
                                mem_req    <= 1'b1;
                                mem_addr   <= cbr + {7'h00, req_line, 4'h0};
                            end
                        end else begin
                            state    <= BYPASS;
                            mem_req  <= 1'b1;
                            mem_addr <= fetch_addr;
                        end
                    end
                end
                LOOKUP: state <= READ;
                READ: begin
                    fetch_data  <= ram_data;
                    fetch_ready <= 1'b1;
                    state       <= RESP;
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt      <= cnt + 4'd1;
                        mem_addr <= mem_addr + 16'd1;
                        if (cnt == 4'hF) begin
                            // A flush seen at any point of this fill leaves the line invalid.
                            mem_req          <= 1'b0;
                            valid[fill_line] <= !(fill_inval || flush);
                            state            <= LOOKUP;
                        end
                    end
                end
                BYPASS: begin
                    if (mem_ack) begin
                        fetch_data  <= mem_data;
                        fetch_ready <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsu_cache_controller.sv
// Bench for gsu_cache_controller: directed vector table, flush/reset corner cases, then random fetches
// checked against a line-valid model of the cache with a pure-function external memory.
module tb_gsu_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = 16'h0;
    logic        fetch_ready;
    logic [7:0]  fetch_data;
    logic        cbr_load = 1'b0;
    logic [11:0] cbr_value = 12'h0;
    logic        flush = 1'b0;
    logic [15:0] cbr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h0;
    logic [8:0]  ram_address;
    logic [7:0]  ram_inst;
    logic        ram_we;
    logic [7:0]  ram_q = 8'h0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    gsu_cache_controller dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .cbr_load(cbr_load), .cbr_value(cbr_value), .flush(flush), .cbr(cbr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .ram_address(ram_address), .ram_inst(ram_inst), .ram_we(ram_we), .ram_data(ram_q)
    );

    // 512x8 synchronous cache RAM
    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (ram_we)
            ram[ram_address] <= ram_inst;
        ram_q <= ram[ram_address];
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // External memory: random wait, one-cycle ack, then at least one idle cycle
    always @(negedge clk) begin
        if (!rst_n || mem_ack || !mem_req)
            mem_ack = 1'b0;
        else
            mem_ack = ($urandom_range(0, 2) != 0);
        mem_data = mem_ack ? mem_byte(mem_addr) : 8'h00;
    end

    logic [15:0] rd_log[$];
    logic [8:0]  wr_log[$];
    int          bad_we = 0;
    int          b2b = 0;
    logic        prev_rdy = 1'b0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ack)
                rd_log.push_back(mem_addr);
            if (ram_we) begin
                wr_log.push_back(ram_address);
                if (!(mem_req && mem_ack) || ram_inst !== mem_data)
                    bad_we <= bad_we + 1;
            end
            if (fetch_ready && prev_rdy)
                b2b <= b2b + 1;
            prev_rdy <= fetch_ready;
        end else begin
            prev_rdy <= 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          ld;
        logic [11:0] v;
        logic [15:0] a;
        int          rd;
        logic [15:0] rd0;
        int          wr;
        logic [8:0]  wa0;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, " fetch_ready"}, 32'(fetch_ready), 0);
        chk({tag, " fetch_data"}, 32'(fetch_data), 0);
        chk({tag, " cbr"}, 32'(cbr), 0);
        chk({tag, " mem_req"}, 32'(mem_req), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " ram_we"}, 32'(ram_we), 0);
        chk({tag, " ram_address"}, 32'(ram_address), 0);
        chk({tag, " ram_inst"}, 32'(ram_inst), 0);
    endtask

    task automatic do_fetch(input bit ld, input logic [11:0] v, input logic [15:0] a,
                            output logic [7:0] d, output int lat, output int r0, output int w0);
        bit got = 1'b0;
        r0 = rd_log.size();
        w0 = wr_log.size();
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
        cbr_load   = ld;
        cbr_value  = v;
        lat = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (cbr_load) begin
                chk("cbr after load", 32'(cbr), 32'({v, 4'h0}));
                cbr_load = 1'b0;
            end
            if (fetch_ready)
                got = 1'b1;
        end
        chk("fetch_ready within bound", 32'(got), 1);
        d = fetch_data;
        fetch_req = 1'b0;
        @(posedge clk);
    endtask

    task automatic verify(input string tag, input vec_t e, input logic [7:0] d,
                          input int lat, input int r0, input int w0);
        int nr, nw;
        bit ok;
        nr = rd_log.size() - r0;
        nw = wr_log.size() - w0;
        chk({tag, " data"}, 32'(d), 32'(mem_byte(e.a)));
        chk({tag, " mem reads"}, nr, e.rd);
        chk({tag, " ram writes"}, nw, e.wr);
        if (e.rd > 0 && nr > 0) begin
            ok = 1'b1;
            for (int i = 0; i < nr; i++)
                if (rd_log[r0 + i] !== e.rd0 + 16'(i)) ok = 1'b0;
            chk({tag, " read addr seq"}, 32'(ok), 1);
        end
        if (e.wr > 0 && nw > 0) begin
            ok = 1'b1;
            for (int i = 0; i < nw; i++)
                if (wr_log[w0 + i] !== e.wa0 + 9'(i)) ok = 1'b0;
            chk({tag, " write addr seq"}, 32'(ok), 1);
        end
        if (e.lat != 0)
            chk({tag, " hit latency"}, lat, e.lat);
    endtask

    vec_t        tbl[10];
    vec_t        e;
    logic [7:0]  d;
    int          lat, r0, w0, sb;
    logic [15:0] m_cbr;
    bit          m_valid[32];

    initial begin
        // cold miss, hit, bypass, range edges, wrap, load+fetch priority
        tbl[0] = '{1'b1, 12'h010, 16'h0123, 16, 16'h0120, 16, 9'h020, 0};
        tbl[1] = '{1'b0, 12'h000, 16'h0125, 0,  16'h0000, 0,  9'h000, 3};
        tbl[2] = '{1'b0, 12'h000, 16'h0400, 1,  16'h0400, 0,  9'h000, 0};
        tbl[3] = '{1'b0, 12'h000, 16'h02FF, 16, 16'h02F0, 16, 9'h1F0, 0};
        tbl[4] = '{1'b0, 12'h000, 16'h00FF, 1,  16'h00FF, 0,  9'h000, 0};
        tbl[5] = '{1'b0, 12'h000, 16'h0300, 1,  16'h0300, 0,  9'h000, 0};
        tbl[6] = '{1'b1, 12'hFF0, 16'h0050, 16, 16'h0050, 16, 9'h150, 0};
        tbl[7] = '{1'b0, 12'h000, 16'h0123, 1,  16'h0123, 0,  9'h000, 0};
        tbl[8] = '{1'b0, 12'h000, 16'h005F, 0,  16'h0000, 0,  9'h000, 3};
        tbl[9] = '{1'b1, 12'hFF0, 16'h0055, 16, 16'h0050, 16, 9'h150, 0};

        #1;
        chk_outs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("post-reset idle");

        for (int i = 0; i < 10; i++) begin
            do_fetch(tbl[i].ld, tbl[i].v, tbl[i].a, d, lat, r0, w0);
            verify($sformatf("vec%0d", i), tbl[i], d, lat, r0, w0);
        end

        // flush after the 5th byte of a fill: fill completes, line stays invalid
        sb = rd_log.size();
        fork
            do_fetch(1'b1, 12'h010, 16'h0123, d, lat, r0, w0);
            begin
                for (int i = 0; i < 300 && rd_log.size() < sb + 5; i++)
                    @(posedge clk);
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        verify("flush-fill", '{1'b1, 12'h010, 16'h0123, 16, 16'h0120, 16, 9'h020, 0}, d, lat, r0, w0);
        do_fetch(1'b0, 12'h000, 16'h0125, d, lat, r0, w0);
        verify("refill", '{1'b0, 12'h000, 16'h0125, 16, 16'h0120, 16, 9'h020, 0}, d, lat, r0, w0);
        do_fetch(1'b0, 12'h000, 16'h0127, d, lat, r0, w0);
        verify("hit after refill", '{1'b0, 12'h000, 16'h0127, 0, 16'h0000, 0, 9'h000, 3}, d, lat, r0, w0);

        // reset mid-fill abandons the line
        do_fetch(1'b1, 12'h000, 16'h0010, d, lat, r0, w0);
        sb = rd_log.size();
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0033;
        for (int i = 0; i < 300 && rd_log.size() < sb + 3; i++)
            @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("reset mid-fill");
        fetch_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(1'b0, 12'h000, 16'h0033, d, lat, r0, w0);
        verify("after reset", '{1'b0, 12'h000, 16'h0033, 16, 16'h0030, 16, 9'h030, 0}, d, lat, r0, w0);

        // randomized fetches against a line-valid model
        m_cbr = 16'h0;
        foreach (m_valid[k]) m_valid[k] = 1'b0;
        for (int n = 0; n < 80; n++) begin
            logic [15:0] nb, off;
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                foreach (m_valid[k]) m_valid[k] = 1'b0;
            end
            e.ld = (n == 0) || ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: e.v = 12'h010;
                1: e.v = 12'hFF0;
                2: e.v = 12'h7A3;
                default: e.v = 12'($urandom);
            endcase
            nb  = e.ld ? {e.v, 4'h0} : m_cbr;
            off = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h5F))
                                              : 16'($urandom_range(0, 16'h27F));
            e.a = nb + off;
            if (e.ld) begin
                m_cbr = nb;
                foreach (m_valid[k]) m_valid[k] = 1'b0;
            end
            off = e.a - m_cbr;
            e.rd = 0; e.rd0 = 16'h0; e.wr = 0; e.wa0 = 9'h0; e.lat = 0;
            if (off < 16'd512) begin
                if (m_valid[off / 16]) begin
                    e.lat = 3;
                end else begin
                    e.rd  = 16;
                    e.wr  = 16;
                    e.rd0 = m_cbr + (off / 16) * 16;
                    e.wa0 = 9'((off / 16) * 16);
                    m_valid[off / 16] = 1'b1;
                end
            end else begin
                e.rd  = 1;
                e.rd0 = e.a;
            end
            do_fetch(e.ld, e.v, e.a, d, lat, r0, w0);
            verify($sformatf("rand%0d", n), e, d, lat, r0, w0);
        end

        chk("fetch_ready never back-to-back", b2b, 0);
        chk("ram_we only with mem_ack", bad_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
